vga_timing: RTL and testbench
=============================

// Module: vga_timing
// PURPOSE
//  Raster timing generator for the 640x480@60 Hz Pong display; directly upstream of the field/paddle/ball renderers.
//  Produces the pixel enable, beam position (pos_h, pos_v), blank and hsync/vsync that renderers consume.
//  Renderers sample pos_h/pos_v/blank on pix_en cycles and register colour; this block does no colour logic.
// PARAMETERS
//  PIX_DIV   4    system clocks per pixel (100 MHz -> 25 MHz); legal 1..16
//  H_VIS     640  visible pixels per line
//  H_FP      16   horizontal front porch
//  H_SYNC    96   hsync width
//  H_BP      48   horizontal back porch (H_TOTAL = 800)
//  V_VIS     480  visible lines
//  V_FP      10   vertical front porch
//  V_SYNC    2    vsync width
//  V_BP      33   vertical back porch (V_TOTAL = 525)
// PORTS
//  clk     in   1   system clock
//  rst_n   in   1   synchronous reset, active low
//  pix_en  out  1   one-clk pulse; pixel advance strobe
//  pos_h   out  10  beam column, 0..799
//  pos_v   out  10  beam line, 0..524
//  blank   out  1   1 = outside visible area
//  hsync   out  1   horizontal sync, active low
//  vsync   out  1   vertical sync, active low
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge clk): div_cnt=0, pos_h=0, pos_v=0, hsync=1, vsync=1, blank=0; pix_en=0 (1 if PIX_DIV==1).
//  - Divider: div_cnt counts 0..PIX_DIV-1 and wraps; pix_en = (div_cnt==PIX_DIV-1); first pix_en at PIX_DIV-1 clks after release.
//  - H phase FSM on pix_en: ACTIVE(0..639) -> FRONT(640..655) -> SYNC(656..751) -> BACK(752..799) -> ACTIVE.
//  - pos_h advances by 1 only on clocks with pix_en=1; 799 -> 0 wraps and same edge increments pos_v.
//  - pos_v 524 -> 0 wraps on the edge where pos_h 799 -> 0 (frame boundary); no other pos_v change.
//  - hsync/vsync/blank are registers computed from the next counter values: always consistent with current pos_h/pos_v, zero lag.
//  - hsync=0 iff 656<=pos_h<=751; vsync=0 iff 490<=pos_v<=491; blank=1 iff pos_h>=640 or pos_v>=480.
//  - Between pix_en pulses all outputs hold.
//  - Reset mid-frame: next clk returns to (0,0) state above regardless of phase or div_cnt.
//  - Width: boundaries from parameter sums, 10-bit compare; H_TOTAL/V_TOTAL must be <=1024 (elaboration check).
// CONFIGURATION
//  - Macro VGA_FRAME_COUNT_EN defined: adds outputs frame_tick (1 clk, pix_en edge on which pos_h,pos_v wrap to 0,0) and frame_cnt[7:0] (incr on frame_tick, wraps 255->0, reset 0).
//  - Not defined: ports absent, no frame counter logic; all other behaviour identical.
// STRUCTURE
//  - Package vga_timing_pkg: 640x480 timing constants, H_TOTAL/V_TOTAL, h_phase_t enum {ACTIVE,FRONT,SYNC,BACK}.
//  - Sub-module pix_en_div (parameter PIX_DIV; clk, rst_n -> pix_en); counters/FSM stay in vga_timing.
// TESTING
//  - Reset: hold rst_n=0 5 clks -> pos_h=0,pos_v=0,hsync=1,vsync=1,blank=0; first pix_en on clk 3 after release (PIX_DIV=4).
//  - Line timing: run one line -> pix_en every 4 clks, hsync low for exactly 96 pix_en (pos_h 656..751), blank high pos_h 640..799.
//  - Line wrap: at pos_h=799,pos_v=10 next pix_en -> pos_h=0,pos_v=11, blank=0.
//  - Frame: run 800*525 pix_en -> vsync low exactly 1600 pixels (lines 490,491), returns to (0,0); with VGA_FRAME_COUNT_EN frame_tick once, frame_cnt=1.
//  - Mid-frame reset: rst_n=0 one clk at pos_h=700,pos_v=300 -> (0,0), hsync=1, div_cnt restarts.
//  - PIX_DIV=1: pix_en constant 1 after reset, pos_h increments every clk.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Timing constants and shared types for the 640x480@60 Hz raster generator.
// Also defines the horizontal phase enum used by the line FSM.
package vga_timing_pkg;

   localparam int POS_W = 10;

   localparam int VGA_H_VIS  = 640;
   localparam int VGA_H_FP   = 16;
   localparam int VGA_H_SYNC = 96;
   localparam int VGA_H_BP   = 48;
   localparam int VGA_V_VIS  = 480;
   localparam int VGA_V_FP   = 10;
   localparam int VGA_V_SYNC = 2;
   localparam int VGA_V_BP   = 33;

   localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} h_phase_t;

endpackage

// File: rtl/vga_timing_if.sv
// Beam position / sync bundle from the timing generator to the renderers.
// VGA_FRAME_COUNT_EN adds frame_tick and frame_cnt.
interface vga_timing_if;
   import vga_timing_pkg::*;

   logic             pix_en;
   logic [POS_W-1:0] pos_h;
   logic [POS_W-1:0] pos_v;
   logic             blank;
   logic             hsync;
   logic             vsync;
`ifdef VGA_FRAME_COUNT_EN
   logic             frame_tick;
   logic [7:0]       frame_cnt;

   modport master (output pix_en, pos_h, pos_v, blank, hsync, vsync, frame_tick, frame_cnt);
   modport slave  (input  pix_en, pos_h, pos_v, blank, hsync, vsync, frame_tick, frame_cnt);
`else
   modport master (output pix_en, pos_h, pos_v, blank, hsync, vsync);
   modport slave  (input  pix_en, pos_h, pos_v, blank, hsync, vsync);
`endif

endinterface

// File: rtl/vga_timing_pix_en_div.sv
// Pixel-enable divider: one-clock strobe every PIX_DIV system clocks, first strobe PIX_DIV-1 clocks after reset.
// No backpressure; free-running, constant high when PIX_DIV==1.
module pix_en_div #(
   parameter int PIX_DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_pix_en
);

   localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);

   logic [3:0] r_div_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_div_cnt <= '0;
      end else if (r_div_cnt == DIV_LAST) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + 4'd1;
      end
   end

   assign o_pix_en = (r_div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: beam counters, line-phase FSM and registered sync/blank, zero lag to pos_h/pos_v.
// No backpressure; VGA_FRAME_COUNT_EN adds frame_tick/frame_cnt.
module vga_timing
   import vga_timing_pkg::*;
#(
   parameter int PIX_DIV = 4,
   parameter int H_VIS   = VGA_H_VIS,
   parameter int H_FP    = VGA_H_FP,
   parameter int H_SYNC  = VGA_H_SYNC,
   parameter int H_BP    = VGA_H_BP,
   parameter int V_VIS   = VGA_V_VIS,
   parameter int V_FP    = VGA_V_FP,
   parameter int V_SYNC  = VGA_V_SYNC,
   parameter int V_BP    = VGA_V_BP
) (
   input  logic i_clk,
   input  logic i_rst_n,
   vga_timing_if.master o_vga
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

   if (H_TOT > 1024 || V_TOT > 1024) begin : g_size_chk
      $error("vga_timing: line/frame total exceeds the 10-bit counter range");
   end
   if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_div_chk
      $error("vga_timing: PIX_DIV must be 1..16");
   end

   localparam logic [POS_W-1:0] H_ACT_END   = 10'(H_VIS - 1);
   localparam logic [POS_W-1:0] H_FP_END    = 10'(H_VIS + H_FP - 1);
   localparam logic [POS_W-1:0] H_SYNC_END  = 10'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [POS_W-1:0] H_LAST      = 10'(H_TOT - 1);
   localparam logic [POS_W-1:0] V_VIS_L     = 10'(V_VIS);
   localparam logic [POS_W-1:0] V_SYNC_BEG  = 10'(V_VIS + V_FP);
   localparam logic [POS_W-1:0] V_SYNC_END  = 10'(V_VIS + V_FP + V_SYNC - 1);
   localparam logic [POS_W-1:0] V_LAST      = 10'(V_TOT - 1);

   logic             w_pix_en;
   logic             w_h_wrap;
   logic [POS_W-1:0] w_pos_h_nxt;
   logic [POS_W-1:0] w_pos_v_nxt;
   h_phase_t         w_h_phase_nxt;
   logic             w_hsync_nxt;
   logic             w_vsync_nxt;
   logic             w_blank_nxt;

   logic [POS_W-1:0] r_pos_h;
   logic [POS_W-1:0] r_pos_v;
   h_phase_t         r_h_phase;
   logic             r_hsync;
   logic             r_vsync;
   logic             r_blank;

   pix_en_div #(.PIX_DIV(PIX_DIV)) u_pix_en_div (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .o_pix_en (w_pix_en)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_pos_h   <= '0;
         r_pos_v   <= '0;
         r_h_phase <= ACTIVE;
         r_hsync   <= 1'b1;
         r_vsync   <= 1'b1;
         r_blank   <= 1'b0;
      end else begin
         r_pos_h   <= w_pos_h_nxt;
         r_pos_v   <= w_pos_v_nxt;
         r_h_phase <= w_h_phase_nxt;
         r_hsync   <= w_hsync_nxt;
         r_vsync   <= w_vsync_nxt;
         r_blank   <= w_blank_nxt;
      end
   end

   // Sync/blank are derived from the next-state values so the registers line up with pos_h/pos_v.
   always_comb begin
      w_h_wrap      = (r_pos_h == H_LAST);
      w_pos_h_nxt   = r_pos_h;
      w_pos_v_nxt   = r_pos_v;
      w_h_phase_nxt = r_h_phase;
      if (w_pix_en) begin
         w_pos_h_nxt = w_h_wrap ? '0 : r_pos_h + 10'd1;
         if (w_h_wrap) begin
            w_pos_v_nxt = (r_pos_v == V_LAST) ? '0 : r_pos_v + 10'd1;
         end
         case (r_h_phase)
            ACTIVE: if (r_pos_h == H_ACT_END)  w_h_phase_nxt = FRONT;
            FRONT:  if (r_pos_h == H_FP_END)   w_h_phase_nxt = SYNC;
            SYNC:   if (r_pos_h == H_SYNC_END) w_h_phase_nxt = BACK;
            BACK:   if (w_h_wrap)              w_h_phase_nxt = ACTIVE;
         endcase
      end
      w_hsync_nxt = (w_h_phase_nxt != SYNC);
      w_vsync_nxt = !((w_pos_v_nxt >= V_SYNC_BEG) && (w_pos_v_nxt <= V_SYNC_END));
      w_blank_nxt = (w_h_phase_nxt != ACTIVE) || (w_pos_v_nxt >= V_VIS_L);
   end

   assign o_vga.pix_en = w_pix_en;
   assign o_vga.pos_h  = r_pos_h;
   assign o_vga.pos_v  = r_pos_v;
   assign o_vga.blank  = r_blank;
   assign o_vga.hsync  = r_hsync;
   assign o_vga.vsync  = r_vsync;

`ifdef VGA_FRAME_COUNT_EN
   logic       w_frame_tick;
   logic [7:0] r_frame_cnt;

   assign w_frame_tick = w_pix_en && w_h_wrap && (r_pos_v == V_LAST);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_frame_cnt <= '0;
      end else if (w_frame_tick) begin
         r_frame_cnt <= r_frame_cnt + 8'd1;
      end
   end

   assign o_vga.frame_tick = w_frame_tick;
   assign o_vga.frame_cnt  = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench: full-size 640x480 generator (PIX_DIV=4) plus a shrunken PIX_DIV=1 instance for whole-frame behaviour.
module tb_vga_timing;

   localparam int AD = 4;
   localparam int AHV = 640, AHF = 16, AHS = 96, AHB = 48;
   localparam int AVV = 480, AVF = 10, AVS = 2,  AVB = 33;
   localparam int BD = 1;
   localparam int BHV = 8, BHF = 2, BHS = 3, BHB = 2;
   localparam int BVV = 6, BVF = 2, BVS = 2, BVB = 3;

   logic clk = 1'b0;
   logic rst_a = 1'b0;
   logic rst_b = 1'b0;
   bit   chk_on = 1'b0;
   int   k_a = 0;
   int   k_b = 0;
   int   n_total = 0;
   int   n_bad = 0;

   vga_timing_if vga_a ();
   vga_timing_if vga_b ();

   vga_timing #(.PIX_DIV(AD)) u_dut_a (
      .i_clk   (clk),
      .i_rst_n (rst_a),
      .o_vga   (vga_a)
   );

   vga_timing #(
      .PIX_DIV(BD),
      .H_VIS(BHV), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
      .V_VIS(BVV), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB)
   ) u_dut_b (
      .i_clk   (clk),
      .i_rst_n (rst_b),
      .o_vga   (vga_b)
   );

   always #5 clk = ~clk;

   // k = clocks since reset release; every output follows from k alone.
   always @(posedge clk) begin
      k_a <= rst_a ? k_a + 1 : 0;
      k_b <= rst_b ? k_b + 1 : 0;
   end

   function automatic logic [31:0] model(input int k, input int d, input int hv, input int hf,
                                         input int hs, input int hb, input int vv, input int vf,
                                         input int vs, input int vb);
      int ht, vt, p, h, v;
      logic pe, bl, hsy, vsy;
      ht  = hv + hf + hs + hb;
      vt  = vv + vf + vs + vb;
      p   = (k / d) % (ht * vt);
      h   = p % ht;
      v   = p / ht;
      pe  = ((k % d) == (d - 1));
      bl  = (h >= hv) || (v >= vv);
      hsy = !((h >= hv + hf) && (h < hv + hf + hs));
      vsy = !((v >= vv + vf) && (v < vv + vf + vs));
      return {8'd0, pe, 10'(h), 10'(v), bl, hsy, vsy};
   endfunction

   function automatic logic [31:0] model_frame(input int k, input int d, input int ht, input int vt);
      int n;
      logic tick;
      n    = k / d;
      tick = ((k % d) == (d - 1)) && ((n % (ht * vt)) == (ht * vt - 1));
      return {23'd0, tick, 8'((n / (ht * vt)) % 256)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name, input int cycles);
      n_total++;
      n_bad++;
      $display("FAIL %s: condition not reached within %0d cycles", name, cycles);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("model_a", {8'd0, vga_a.pix_en, vga_a.pos_h, vga_a.pos_v, vga_a.blank, vga_a.hsync, vga_a.vsync},
             model(k_a, AD, AHV, AHF, AHS, AHB, AVV, AVF, AVS, AVB));
         chk("model_b", {8'd0, vga_b.pix_en, vga_b.pos_h, vga_b.pos_v, vga_b.blank, vga_b.hsync, vga_b.vsync},
             model(k_b, BD, BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB));
`ifdef VGA_FRAME_COUNT_EN
         chk("model_a_frame", {23'd0, vga_a.frame_tick, vga_a.frame_cnt},
             model_frame(k_a, AD, AHV + AHF + AHS + AHB, AVV + AVF + AVS + AVB));
         chk("model_b_frame", {23'd0, vga_b.frame_tick, vga_b.frame_cnt},
             model_frame(k_b, BD, BHV + BHF + BHS + BHB, BVV + BVF + BVS + BVB));
`endif
      end
   end

   task automatic run_a();
      int pe_cnt, hs_cnt, bl_cnt, hs_min, hs_max, bl_min, gap_min, gap_max, last, c;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk($sformatf("a_first_pix_en_clk%0d", i), 32'(vga_a.pix_en), 32'(i == 3));
      end
      pe_cnt = 0; hs_cnt = 0; bl_cnt = 0; last = -1;
      hs_min = 1023; hs_max = 0; bl_min = 1023; gap_min = 1000; gap_max = 0;
      for (int cy = 0; cy < 800 * AD; cy++) begin
         if (vga_a.pix_en) begin
            if (last >= 0) begin
               if (cy - last < gap_min) gap_min = cy - last;
               if (cy - last > gap_max) gap_max = cy - last;
            end
            last = cy;
            pe_cnt++;
            if (!vga_a.hsync) begin
               hs_cnt++;
               if (int'(vga_a.pos_h) < hs_min) hs_min = int'(vga_a.pos_h);
               if (int'(vga_a.pos_h) > hs_max) hs_max = int'(vga_a.pos_h);
            end
            if (vga_a.blank) begin
               bl_cnt++;
               if (int'(vga_a.pos_h) < bl_min) bl_min = int'(vga_a.pos_h);
            end
         end
         step();
      end
      chk("line_pix_en_cnt", pe_cnt, 800);
      chk("line_pix_gap_min", gap_min, 4);
      chk("line_pix_gap_max", gap_max, 4);
      chk("line_hsync_lo_cnt", hs_cnt, 96);
      chk("line_hsync_first", hs_min, 656);
      chk("line_hsync_last", hs_max, 751);
      chk("line_blank_cnt", bl_cnt, 160);
      chk("line_blank_first", bl_min, 640);

      c = 0;
      while (!(vga_a.pix_en && vga_a.pos_h == 10'd799 && vga_a.pos_v == 10'd10) && c < 40000) begin
         step();
         c++;
      end
      if (c >= 40000) timeout("wrap_wait", c);
      else begin
         chk("pre_wrap_blank", 32'(vga_a.blank), 1);
         step();
         chk("wrap_pos_h", 32'(vga_a.pos_h), 0);
         chk("wrap_pos_v", 32'(vga_a.pos_v), 11);
         chk("wrap_blank", 32'(vga_a.blank), 0);
         chk("wrap_hsync", 32'(vga_a.hsync), 1);
      end

      c = 0;
      while (!(vga_a.pos_h == 10'd700 && vga_a.pos_v == 10'd11) && c < 4000) begin
         step();
         c++;
      end
      if (c >= 4000) timeout("midrst_wait", c);
      else begin
         chk("midrst_pre_hsync", 32'(vga_a.hsync), 0);
         rst_a = 1'b0;
         step();
         rst_a = 1'b1;
         chk("midrst_pos_h", 32'(vga_a.pos_h), 0);
         chk("midrst_pos_v", 32'(vga_a.pos_v), 0);
         chk("midrst_hsync", 32'(vga_a.hsync), 1);
         chk("midrst_blank", 32'(vga_a.blank), 0);
         chk("midrst_pix_en", 32'(vga_a.pix_en), 0);
         for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("midrst_pix_en_clk%0d", i), 32'(vga_a.pix_en), 32'(i == 3));
         end
      end
   endtask

   task automatic run_b();
      int pe_cnt, vs_cnt, ft_cnt, c;
      pe_cnt = 0; vs_cnt = 0; ft_cnt = 0;
      for (int cy = 0; cy < 195; cy++) begin
         step();
         if (cy == 0) chk("b_first_pos_h", 32'(vga_b.pos_h), 1);
         if (vga_b.pix_en) pe_cnt++;
         if (!vga_b.vsync) vs_cnt++;
`ifdef VGA_FRAME_COUNT_EN
         if (vga_b.frame_tick) ft_cnt++;
`endif
      end
      chk("b_pix_en_cnt", pe_cnt, 195);
      chk("b_vsync_lo_cnt", vs_cnt, 30);
      chk("b_frame_end_pos_h", 32'(vga_b.pos_h), 0);
      chk("b_frame_end_pos_v", 32'(vga_b.pos_v), 0);
`ifdef VGA_FRAME_COUNT_EN
      chk("b_frame_tick_cnt", ft_cnt, 1);
      chk("b_frame_cnt", 32'(vga_b.frame_cnt), 1);
`endif
      c = 0;
      while (!(vga_b.pos_h == 10'd5 && vga_b.pos_v == 10'd7) && c < 400) begin
         step();
         c++;
      end
      if (c >= 400) timeout("b_midrst_wait", c);
      else begin
         rst_b = 1'b0;
         step();
         rst_b = 1'b1;
         chk("b_midrst_pos_h", 32'(vga_b.pos_h), 0);
         chk("b_midrst_pos_v", 32'(vga_b.pos_v), 0);
         chk("b_midrst_pix_en", 32'(vga_b.pix_en), 1);
         step();
         chk("b_midrst_next_pos_h", 32'(vga_b.pos_h), 1);
      end
   endtask

   initial begin
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk_on = 1'b1;
      chk("rst_pos_h", 32'(vga_a.pos_h), 0);
      chk("rst_pos_v", 32'(vga_a.pos_v), 0);
      chk("rst_hsync", 32'(vga_a.hsync), 1);
      chk("rst_vsync", 32'(vga_a.vsync), 1);
      chk("rst_blank", 32'(vga_a.blank), 0);
      chk("rst_pix_en", 32'(vga_a.pix_en), 0);
      chk("rst_pix_en_div1", 32'(vga_b.pix_en), 1);
      rst_a = 1'b1;
      rst_b = 1'b1;
      fork
         run_a();
         run_b();
      join
      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
